// File: rtl/state_seq_param_if.sv
// Bus bundle for state_seq_param: step/load controls in, state encodings and pulses out.
// "master" is the block issuing step/load requests; "slave" is the sequencer.
interface state_seq_param_if #(
  parameter int unsigned NUM_STATES = 4
);
  localparam int unsigned BIN_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;

  logic                  next_state;
  logic                  dir;
  logic                  load;
  logic [BIN_W-1:0]      load_state;
  logic [BIN_W-1:0]      state_binary;
  logic [NUM_STATES-1:0] state_onehot;
  logic [BIN_W-1:0]      state_gray;
  logic                  wrap;
  logic                  load_err;
  logic                  enc_err;

  modport master (
    output next_state, dir, load, load_state,
    input  state_binary, state_onehot, state_gray, wrap, load_err, enc_err
  );

  modport slave (
    input  next_state, dir, load, load_state,
    output state_binary, state_onehot, state_gray, wrap, load_err, enc_err
  );
endinterface

// File: rtl/state_seq_param.sv
// Parametrised state sequencer: one state index in 0..NUM_STATES-1, presented as binary,
// one-hot and Gray, with up/down wrap stepping, range-checked load and a wrap pulse.
// Optional macro STATE_CHECK_EN adds a one-hot vs binary integrity checker driving enc_err;
// without it enc_err is tied low.
module state_seq_param #(
  parameter int unsigned NUM_STATES = 4
) (
  input logic               clk,
  input logic               rst_n,
  state_seq_param_if.slave  bus
);
  localparam int unsigned BIN_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [BIN_W-1:0]      MaxState = BIN_W'(NUM_STATES - 1);
  localparam logic [NUM_STATES-1:0] OneHot0  = NUM_STATES'(1);

  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [NUM_STATES-1:0] onehot_q, onehot_d;
  logic [BIN_W-1:0]      gray_q, gray_d;
  logic                  wrap_q, wrap_d;
  logic                  load_err_q, load_err_d;
  logic                  enc_err_q, enc_err_d;
  logic                  fault;

`ifdef STATE_CHECK_EN
  logic [NUM_STATES-1:0] bin_dec;

  // Fault if one-hot disagrees with the binary decode or carries no bit at all.
  always_comb begin
    bin_dec = OneHot0 << bin_q;
    fault   = (onehot_q != bin_dec) || (onehot_q == '0);
  end
`else
  assign fault = 1'b0;
`endif

  // Next state: fault recovery > load > step > hold; one-hot rotates independently of binary.
  always_comb begin
    bin_d      = bin_q;
    onehot_d   = onehot_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    enc_err_d  = enc_err_q | fault;
    if (fault) begin
      bin_d    = '0;
      onehot_d = OneHot0;
    end else if (bus.load) begin
      if (bus.load_state <= MaxState) begin
        bin_d    = bus.load_state;
        onehot_d = OneHot0 << bus.load_state;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.next_state) begin
      if (bus.dir) begin
        onehot_d = {onehot_q[NUM_STATES-2:0], onehot_q[NUM_STATES-1]};
        if (bin_q == MaxState) begin
          bin_d  = '0;
          wrap_d = 1'b1;
        end else begin
          bin_d  = bin_q + BIN_W'(1);
        end
      end else begin
        onehot_d = {onehot_q[0], onehot_q[NUM_STATES-1:1]};
        if (bin_q == '0) begin
          bin_d  = MaxState;
          wrap_d = 1'b1;
        end else begin
          bin_d  = bin_q - BIN_W'(1);
        end
      end
    end
    // Gray is derived from the next binary value so it is registered in step with it.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State and output registers, asynchronously cleared to state 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      onehot_q   <= OneHot0;
      gray_q     <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      enc_err_q  <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      onehot_q   <= onehot_d;
      gray_q     <= gray_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      enc_err_q  <= enc_err_d;
    end
  end

  assign bus.state_binary = bin_q;
  assign bus.state_onehot = onehot_q;
  assign bus.state_gray   = gray_q;
  assign bus.wrap         = wrap_q;
  assign bus.load_err     = load_err_q;
  assign bus.enc_err      = enc_err_q;

endmodule

// File: tb/tb_state_seq_param.sv
// Randomised bench for state_seq_param (NUM_STATES=5) against an arithmetic reference model.
module tb_state_seq_param;
  localparam int unsigned N     = 5;
  localparam int unsigned BIN_W = $clog2(N);

  logic clk;
  logic rst_n;

  state_seq_param_if #(.NUM_STATES(N)) bus ();

  state_seq_param #(.NUM_STATES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Reference model state
  int unsigned m_state;
  bit          m_wrap;
  bit          m_lerr;
  bit          m_enc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] oh;
    logic [31:0] gr;
    oh = 32'd1 << m_state;
    gr = m_state ^ (m_state >> 1);
    check("binary",   32'(bus.state_binary), m_state);
    check("onehot",   32'(bus.state_onehot), oh);
    check("gray",     32'(bus.state_gray),   gr);
    check("wrap",     32'(bus.wrap),         32'(m_wrap));
    check("load_err", 32'(bus.load_err),     32'(m_lerr));
    check("enc_err",  32'(bus.enc_err),      32'(m_enc));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_wrap  = 1'b0;
    m_lerr  = 1'b0;
    m_enc   = 1'b0;
  endtask

  // Apply one set of inputs for one edge, advance the model, check #1 after the edge.
  task automatic cycle(input bit ld, input int unsigned ls, input bit ns, input bit d);
    bus.load       = ld;
    bus.load_state = BIN_W'(ls);
    bus.next_state = ns;
    bus.dir        = d;
    @(posedge clk);
    m_wrap = 1'b0;
    m_lerr = 1'b0;
    if (ld) begin
      if (ls < N) m_state = ls;
      else        m_lerr  = 1'b1;
    end else if (ns) begin
      if (d) begin
        m_wrap  = (m_state == N - 1);
        m_state = (m_state + 1) % N;
      end else begin
        m_wrap  = (m_state == 0);
        m_state = (m_state + N - 1) % N;
      end
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n          = 1'b0;
    bus.load       = 1'b0;
    bus.load_state = '0;
    bus.next_state = 1'b0;
    bus.dir        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);

    // Full up lap, wrap on the last step
    for (int i = 0; i < N; i++) cycle(0, 0, 1, 1);
    // Down from 0 wraps to N-1, then plain decrement
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    // In-range load, then out-of-range loads hold state
    cycle(1, 3, 0, 0);
    cycle(1, 6, 0, 0);
    cycle(1, 7, 1, 1);
    cycle(0, 0, 0, 0);
    // Load beats a simultaneous step
    cycle(1, 2, 1, 1);
    cycle(1, 4, 0, 0);
    cycle(0, 0, 1, 1);
    // Async reset mid-count from state 2
    cycle(1, 2, 0, 0);
    async_reset_pulse();
    cycle(0, 0, 1, 1);

    // Random traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset_pulse();
      end else begin
        cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

`ifdef STATE_CHECK_EN
    // Corrupt the one-hot register; the next edge must recover to 0 and set enc_err.
    cycle(1, 2, 0, 0);
    force dut.onehot_q = 5'b00110;
    #1;
    release dut.onehot_q;
    bus.load       = 1'b1;
    bus.load_state = 3'd4;
    bus.next_state = 1'b1;
    bus.dir        = 1'b1;
    @(posedge clk);
    m_state = 0;
    m_wrap  = 1'b0;
    m_lerr  = 1'b0;
    m_enc   = 1'b1;
    #1;
    check_all();
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1'($urandom_range(0, 1)));
    async_reset_pulse();
    cycle(0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
